// File: rtl/pipeline_write_tracker_pkg.sv
// Shared pipeline tracking types and constants.
// Optional feature macro used by the top: PIPELINE_STALL_COUNT_EN.
package pipeline_write_tracker_pkg;

    localparam int REG_W = 5;
    localparam logic [REG_W-1:0] ZERO_REG = 5'd31;

    // One pipeline stage's view of the instruction it holds.
    typedef struct packed {
        logic [REG_W-1:0] writeReg;
        logic             RegWrite;
        logic             MemRead;
    } track_entry_t;

    // Empty slot: targets XZR, writes nothing, is not a load.
    localparam track_entry_t BUBBLE = '{writeReg: ZERO_REG, RegWrite: 1'b0, MemRead: 1'b0};

endpackage

// File: rtl/pipeline_track_stage.sv
// Single tracking entry: resets to BUBBLE, loads on i_load_en,
// and loads BUBBLE instead of i_d when i_bubble_sel is set.
module pipeline_track_stage
    import pipeline_write_tracker_pkg::*;
(
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_load_en,
    input  logic         i_bubble_sel,
    input  track_entry_t i_d,
    output track_entry_t o_q
);

    track_entry_t r_q;

    // Entry register: hold when not enabled, else capture data or a bubble.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q <= BUBBLE;
        end else if (i_load_en) begin
            r_q <= i_bubble_sel ? BUBBLE : i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/pipeline_write_tracker.sv
// Tracks destination/write-enable/load info of instructions through
// EX, MEM and WB, and raises a one-cycle load-use stall against ID.
// Define PIPELINE_STALL_COUNT_EN to add the saturating stallCount output.
module pipeline_write_tracker #(
    parameter int               REG_W    = pipeline_write_tracker_pkg::REG_W,
    parameter logic [REG_W-1:0] ZERO_REG = pipeline_write_tracker_pkg::ZERO_REG
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] writeReg_ID,
    input  logic             RegWrite_ID,
    input  logic             MemRead_ID,
    input  logic [REG_W-1:0] readRegA_ID,
    input  logic [REG_W-1:0] readRegB_ID,
    input  logic             hold,
    input  logic             flush,
    output logic [REG_W-1:0] writeReg_EX,
    output logic [REG_W-1:0] writeReg_MEM,
    output logic [REG_W-1:0] writeReg_WB,
    output logic             RegWrite_EX,
    output logic             RegWrite_MEM,
    output logic             RegWrite_WB,
`ifdef PIPELINE_STALL_COUNT_EN
    output logic             stall,
    output logic [31:0]      stallCount
`else
    output logic             stall
`endif
);

    import pipeline_write_tracker_pkg::track_entry_t;

    track_entry_t w_id_entry;
    track_entry_t w_ex_q;
    track_entry_t w_mem_q;
    track_entry_t w_wb_q;
    logic         w_advance;
    logic         w_ex_bubble;
    logic         w_stall;
    logic         w_unused_wb_memread;

    // A write to XZR is captured as a non-write so nothing downstream forwards it.
    assign w_id_entry.writeReg = writeReg_ID;
    assign w_id_entry.RegWrite = RegWrite_ID & (writeReg_ID != ZERO_REG);
    assign w_id_entry.MemRead  = MemRead_ID;

    // Load-use hazard: a real load in EX whose destination is read by ID.
    assign w_stall = w_ex_q.MemRead & w_ex_q.RegWrite & (w_ex_q.writeReg != ZERO_REG)
                   & ((w_ex_q.writeReg == readRegA_ID) | (w_ex_q.writeReg == readRegB_ID));

    // hold freezes everything; flush or stall insert a bubble into EX.
    assign w_advance   = ~hold;
    assign w_ex_bubble = flush | w_stall;

    pipeline_track_stage u_ex (
        .i_clk        (clk),
        .i_rst_n      (reset),
        .i_load_en    (w_advance),
        .i_bubble_sel (w_ex_bubble),
        .i_d          (w_id_entry),
        .o_q          (w_ex_q)
    );

    pipeline_track_stage u_mem (
        .i_clk        (clk),
        .i_rst_n      (reset),
        .i_load_en    (w_advance),
        .i_bubble_sel (1'b0),
        .i_d          (w_ex_q),
        .o_q          (w_mem_q)
    );

    pipeline_track_stage u_wb (
        .i_clk        (clk),
        .i_rst_n      (reset),
        .i_load_en    (w_advance),
        .i_bubble_sel (1'b0),
        .i_d          (w_mem_q),
        .o_q          (w_wb_q)
    );

    // The load flag is not needed once the instruction has left MEM.
    assign w_unused_wb_memread = w_wb_q.MemRead;

    assign writeReg_EX  = w_ex_q.writeReg;
    assign writeReg_MEM = w_mem_q.writeReg;
    assign writeReg_WB  = w_wb_q.writeReg;
    assign RegWrite_EX  = w_ex_q.RegWrite;
    assign RegWrite_MEM = w_mem_q.RegWrite;
    assign RegWrite_WB  = w_wb_q.RegWrite;
    assign stall        = w_stall;

`ifdef PIPELINE_STALL_COUNT_EN
    logic [31:0] r_stall_count;

    // Count edges on which a stall actually takes effect; saturate at all-ones.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_count <= 32'd0;
        end else if (w_stall && !hold && (r_stall_count != 32'hFFFF_FFFF)) begin
            r_stall_count <= r_stall_count + 32'd1;
        end
    end

    assign stallCount = r_stall_count;
`endif

endmodule

// File: tb/tb_pipeline_write_tracker.sv
// Self-checking bench for pipeline_write_tracker: directed table,
// hand-written reset sequence, then randomized run against a stage model.
module tb_pipeline_write_tracker;

  localparam logic [4:0] ZR = 5'd31;
  localparam int OW = 19;

  logic        clk;
  logic        reset;
  logic [4:0]  writeReg_ID;
  logic        RegWrite_ID;
  logic        MemRead_ID;
  logic [4:0]  readRegA_ID;
  logic [4:0]  readRegB_ID;
  logic        hold;
  logic        flush;
  logic [4:0]  writeReg_EX;
  logic [4:0]  writeReg_MEM;
  logic [4:0]  writeReg_WB;
  logic        RegWrite_EX;
  logic        RegWrite_MEM;
  logic        RegWrite_WB;
  logic        stall;
`ifdef PIPELINE_STALL_COUNT_EN
  logic [31:0] stallCount;
`endif

  int n_checks = 0;
  int n_errors = 0;

  pipeline_write_tracker dut (
    .clk          (clk),
    .reset        (reset),
    .writeReg_ID  (writeReg_ID),
    .RegWrite_ID  (RegWrite_ID),
    .MemRead_ID   (MemRead_ID),
    .readRegA_ID  (readRegA_ID),
    .readRegB_ID  (readRegB_ID),
    .hold         (hold),
    .flush        (flush),
    .writeReg_EX  (writeReg_EX),
    .writeReg_MEM (writeReg_MEM),
    .writeReg_WB  (writeReg_WB),
    .RegWrite_EX  (RegWrite_EX),
    .RegWrite_MEM (RegWrite_MEM),
    .RegWrite_WB  (RegWrite_WB),
`ifdef PIPELINE_STALL_COUNT_EN
    .stall        (stall),
    .stallCount   (stallCount)
`else
    .stall        (stall)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [4:0] wr, input logic rw, input logic mr,
                       input logic [4:0] ra, input logic [4:0] rb,
                       input logic hd, input logic fl);
    writeReg_ID = wr;
    RegWrite_ID = rw;
    MemRead_ID  = mr;
    readRegA_ID = ra;
    readRegB_ID = rb;
    hold        = hd;
    flush       = fl;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag,
                               input logic [4:0] ewr_ex, input logic erw_ex,
                               input logic [4:0] ewr_mem, input logic erw_mem,
                               input logic [4:0] ewr_wb, input logic erw_wb,
                               input logic est, input int ecnt);
    check({tag, " writeReg_EX"},  32'(writeReg_EX),  32'(ewr_ex));
    check({tag, " RegWrite_EX"},  32'(RegWrite_EX),  32'(erw_ex));
    check({tag, " writeReg_MEM"}, 32'(writeReg_MEM), 32'(ewr_mem));
    check({tag, " RegWrite_MEM"}, 32'(RegWrite_MEM), 32'(erw_mem));
    check({tag, " writeReg_WB"},  32'(writeReg_WB),  32'(ewr_wb));
    check({tag, " RegWrite_WB"},  32'(RegWrite_WB),  32'(erw_wb));
    check({tag, " stall"},        32'(stall),        32'(est));
`ifdef PIPELINE_STALL_COUNT_EN
    check({tag, " stallCount"},   stallCount,        32'(ecnt));
`else
    if (ecnt < 0) $display("note: negative count %0d", ecnt);
`endif
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [4:0] wr; logic rw; logic mr; logic [4:0] ra; logic [4:0] rb; logic hd; logic fl;
    logic [4:0] e_wr_ex; logic e_rw_ex; logic [4:0] e_wr_mem; logic e_rw_mem;
    logic [4:0] e_wr_wb; logic e_rw_wb; logic e_stall; int e_cnt;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs[NV];

  function automatic vec_t mk(int wr, int rw, int mr, int ra, int rb, int hd, int fl,
                              int ewx, int erx, int ewm, int erm, int eww, int erw,
                              int est, int ecnt);
    vec_t v;
    v.wr = 5'(wr); v.rw = 1'(rw); v.mr = 1'(mr); v.ra = 5'(ra); v.rb = 5'(rb);
    v.hd = 1'(hd); v.fl = 1'(fl);
    v.e_wr_ex = 5'(ewx); v.e_rw_ex = 1'(erx); v.e_wr_mem = 5'(ewm); v.e_rw_mem = 1'(erm);
    v.e_wr_wb = 5'(eww); v.e_rw_wb = 1'(erw); v.e_stall = 1'(est); v.e_cnt = ecnt;
    return v;
  endfunction

  // ---------------- reference model ----------------
  typedef struct { logic [4:0] wr; logic rw; logic mr; } ent_t;
  ent_t   m_stage[3];   // 0=EX 1=MEM 2=WB
  longint m_cnt;

  function automatic logic model_stall();
    ent_t ex;
    ex = m_stage[0];
    return ex.mr && ex.rw && (ex.wr != ZR) && (ex.wr == readRegA_ID || ex.wr == readRegB_ID);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) m_stage[i] = '{wr: ZR, rw: 1'b0, mr: 1'b0};
    m_cnt = 0;
  endtask

  task automatic model_edge();
    logic s;
    s = model_stall();
    if (!hold) begin
      if (s && m_cnt < 64'hFFFF_FFFF) m_cnt++;
      m_stage[2] = m_stage[1];
      m_stage[1] = m_stage[0];
      if (flush || s) m_stage[0] = '{wr: ZR, rw: 1'b0, mr: 1'b0};
      else m_stage[0] = '{wr: writeReg_ID, rw: RegWrite_ID && (writeReg_ID != ZR), mr: MemRead_ID};
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [OW-1:0] exp_q[$];

  // ---------------- main sequence ----------------
  initial begin
    logic [OW-1:0] e;
    vecs[0]  = mk(10,1,0, 0,0,0,0, 31,0,31,0,31,0,0,0);
    vecs[1]  = mk(31,1,0, 0,0,0,0, 10,1,31,0,31,0,0,0);
    vecs[2]  = mk( 5,1,1, 0,0,0,0, 31,0,10,1,31,0,0,0);
    vecs[3]  = mk( 6,1,0, 5,0,0,0,  5,1,31,0,10,1,1,0);
    vecs[4]  = mk( 6,1,0, 5,0,0,0, 31,0, 5,1,31,0,0,1);
    vecs[5]  = mk( 5,1,1, 0,0,0,0,  6,1,31,0, 5,1,0,1);
    vecs[6]  = mk( 9,1,0, 0,5,1,0,  5,1, 6,1,31,0,1,1);
    vecs[7]  = mk( 9,1,0, 0,5,1,0,  5,1, 6,1,31,0,1,1);
    vecs[8]  = mk( 9,1,0, 0,5,1,0,  5,1, 6,1,31,0,1,1);
    vecs[9]  = mk( 9,1,0, 0,5,0,0,  5,1, 6,1,31,0,1,1);
    vecs[10] = mk( 9,1,0, 0,5,0,0, 31,0, 5,1, 6,1,0,2);
    vecs[11] = mk( 7,1,0, 0,0,0,1,  9,1,31,0, 5,1,0,2);
    vecs[12] = mk( 3,1,0, 0,0,0,0, 31,0, 9,1,31,0,0,2);
    vecs[13] = mk(31,1,1,31,0,0,0,  3,1,31,0, 9,1,0,2);
    vecs[14] = mk( 4,1,0,31,31,0,0,31,0, 3,1,31,0,0,2);
    vecs[15] = mk( 8,1,1, 0,0,0,0,  4,1,31,0, 3,1,0,2);
    vecs[16] = mk( 9,1,1, 8,0,0,0,  8,1, 4,1,31,0,1,2);
    vecs[17] = mk( 9,1,1, 8,0,0,0, 31,0, 8,1, 4,1,0,3);
    vecs[18] = mk( 2,1,0, 9,0,0,0,  9,1,31,0, 8,1,1,3);
    vecs[19] = mk( 2,1,0, 9,0,0,0, 31,0, 9,1,31,0,0,4);
    vecs[20] = mk( 0,0,0, 0,0,0,0,  2,1,31,0, 9,1,0,4);

    reset = 1'b0;
    drive(5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;

    // Directed table: inputs applied just after an edge, outputs checked at negedge.
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].wr, vecs[i].rw, vecs[i].mr, vecs[i].ra, vecs[i].rb, vecs[i].hd, vecs[i].fl);
      @(negedge clk);
      check_outputs($sformatf("row%0d", i),
                    vecs[i].e_wr_ex, vecs[i].e_rw_ex, vecs[i].e_wr_mem, vecs[i].e_rw_mem,
                    vecs[i].e_wr_wb, vecs[i].e_rw_wb, vecs[i].e_stall, vecs[i].e_cnt);
      @(posedge clk);
      #1;
    end

    // Fill all three stages, then reset asynchronously between edges.
    drive(5'd11, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive(5'd12, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive(5'd13, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive(5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
    @(negedge clk);
    check_outputs("full", 5'd13, 1'b1, 5'd12, 1'b1, 5'd11, 1'b1, 1'b0, 4);
    #2;
    reset = 1'b0;
    #1;
    check_outputs("async_rst", ZR, 1'b0, ZR, 1'b0, ZR, 1'b0, 1'b0, 0);
    @(posedge clk); #1;
    check_outputs("rst_held", ZR, 1'b0, ZR, 1'b0, ZR, 1'b0, 1'b0, 0);
    reset = 1'b1;
    model_reset();

    // Randomized run against the stage model.
    for (int c = 0; c < 400; c++) begin
      drive(($urandom_range(0, 3) == 0) ? ZR : 5'($urandom_range(0, 7)),
            1'($urandom_range(0, 4) != 0),
            1'($urandom_range(0, 2) == 0),
            ($urandom_range(0, 5) == 0) ? ZR : 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)),
            1'($urandom_range(0, 7) == 0),
            1'($urandom_range(0, 7) == 0));
      exp_q.push_back({m_stage[0].wr, m_stage[0].rw, m_stage[1].wr, m_stage[1].rw,
                       m_stage[2].wr, m_stage[2].rw, model_stall()});
      @(negedge clk);
      e = exp_q.pop_front();
      check_outputs($sformatf("rnd%0d", c), e[18:14], e[13], e[12:8], e[7], e[6:2], e[1], e[0],
                    int'(m_cnt));
      @(posedge clk);
      model_edge();
      #1;
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
